id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding; directly feeds the ALU (A, B, shamt, qByte, ALUOP).
//  Captures decoded operands/control from ID; resolves RAW hazards from EX/MEM and MEM/WB.
//  Flags load-use hazards so the hazard unit can stall IF/ID.
// PARAMETERS
//  WORD_SIZE  32  datapath width
//  REG_ADDR    5  register-file address width
// PORTS
//  i_CLK            in   1          clock, rising edge
//  i_RST            in   1          reset, asynchronous, active-high
//  i_stall          in   1          hold current contents
//  i_flush          in   1          load a bubble
//  i_id_valid       in   1          ID holds a real instruction
//  i_rs_data        in   WORD_SIZE  regfile read A
//  i_rt_data        in   WORD_SIZE  regfile read B
//  i_imm            in   WORD_SIZE  already-extended immediate
//  i_rs_addr        in   REG_ADDR   source A index
//  i_rt_addr        in   REG_ADDR   source B index
//  i_dst_addr       in   REG_ADDR   destination index (rd/rt already chosen)
//  i_shamt          in   $clog2(WORD_SIZE)  shift amount
//  i_qbyte          in   WORD_SIZE/4  quad-byte operand
//  i_aluop          in   4          ALU op code
//  i_alusrc         in   1          1: B = immediate
//  i_regwrite/i_memread/i_memwrite/i_memtoreg  in 1 each  control
//  i_exmem_regwrite in   1 ; i_exmem_dst in REG_ADDR ; i_exmem_result in WORD_SIZE
//  i_memwb_regwrite in   1 ; i_memwb_dst in REG_ADDR ; i_memwb_result in WORD_SIZE
//  o_ex_valid       out  1          EX holds a real instruction
//  o_alu_A, o_alu_B out  WORD_SIZE  forwarded ALU operands
//  o_store_data     out  WORD_SIZE  forwarded rt (for sw)
//  o_shamt, o_qbyte, o_aluop  out  registered copies
//  o_dst_addr       out  REG_ADDR
//  o_regwrite/o_memread/o_memwrite/o_memtoreg  out 1 each, gated by o_ex_valid
//  o_load_use       out  1          hazard request to stall IF/ID
// BEHAVIOUR
//  - Reset: every register 0; o_ex_valid=0, all control 0, operands 0, o_load_use=0.
//  - Per posedge, priority: i_flush > i_stall > load.
//    flush: valid<=0, all control<=0, data don't-care (registered 0).
//    stall: all registers hold; forwarding still re-evaluates each cycle.
//    load: all ID inputs captured; valid<=i_id_valid; control<=control & i_id_valid.
//  - Latency: 1 cycle ID->EX; forwarding is combinational on registered indices.
//  - Forward select per source (rs, rt), evaluated on registered addr:
//    EX/MEM if exmem_regwrite && exmem_dst==src && src!=0;
//    else MEM/WB if memwb_regwrite && memwb_dst==src && src!=0; else registered data.
//    EX/MEM wins when both match. Register 0 never forwarded.
//  - o_alu_A = fwd(rs); o_store_data = fwd(rt); o_alu_B = alusrc ? imm : fwd(rt).
//  - o_load_use = o_ex_valid & memread_q & dst_q!=0 & i_id_valid &
//    (dst_q==i_rs_addr | dst_q==i_rt_addr); combinational, registered inputs + ID.
//    Hazard unit asserts stall upstream and i_flush here the next edge.
//  - Mid-operation reset clears immediately (async); first edge after release loads normally.
//  - Bubble: valid=0 forces aluop 0 (add) and all write/mem control 0.
// STRUCTURE
//  - pipeline_pkg: ALUOP constants (0 ADD,1 SUB,2 SLL,3 AND,4 SRL,5 NOR,6 SRA,7 XOR,
//    8 QUAD,9 LUI,10 OR,11 SLT), FWD_* select encodings (REG, EXMEM, MEMWB).
//  - One sub-module: fwd_mux (src addr + hazards -> 2-bit select + data), instantiated twice.
// TESTING
//  - Reset: assert i_RST mid-run -> all outputs 0 immediately, o_ex_valid=0.
//  - Pass-through: rs=5 data 0x11, rt=6 data 0x22, alusrc=0, no hazards -> next cycle A=0x11, B=0x22.
//  - Double hazard: rs=3, exmem_dst=3 result 0xAAAA, memwb_dst=3 result 0xBBBB -> A=0xAAAA.
//  - R0: rs=0, exmem_dst=0 regwrite=1 result 0xFFFF, rs_data=0 -> A=0.
//  - Load-use: EX has lw dst=7 valid; ID reads rt=7 -> o_load_use=1; flush next edge -> valid=0, regwrite=0.
//  - Stall+flush same edge -> bubble; stall alone 3 cycles -> registers unchanged, A tracks new EX/MEM value.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: ALU op codes and forwarding select encodings.
package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_QUAD = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_OR   = 4'd10,
        ALU_SLT  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: picks EX/MEM, MEM/WB or the registered
// regfile value for one source register index.
module fwd_mux
    import pipeline_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic [REG_ADDR-1:0]  src,
    input  logic [WORD_SIZE-1:0] reg_data,
    input  logic                 exmem_regwrite,
    input  logic [REG_ADDR-1:0]  exmem_dst,
    input  logic [WORD_SIZE-1:0] exmem_result,
    input  logic                 memwb_regwrite,
    input  logic [REG_ADDR-1:0]  memwb_dst,
    input  logic [WORD_SIZE-1:0] memwb_result,
    output logic [WORD_SIZE-1:0] data
);

    fwd_sel_e sel;
    logic     src_nz;
    logic     ex_hit;
    logic     wb_hit;

    assign src_nz = (src != '0);
    assign ex_hit = src_nz && exmem_regwrite && (exmem_dst == src);
    assign wb_hit = src_nz && memwb_regwrite && (memwb_dst == src);

    // The younger producer (EX/MEM) wins when both stages match.
    always_comb begin
        sel = FWD_REG;
        if (ex_hit)
            sel = FWD_EXMEM;
        else if (wb_hit)
            sel = FWD_MEMWB;
    end

    always_comb begin
        data = reg_data;
        unique case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_result;
            default:   data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding into the ALU operands
// and load-use hazard detection against the instruction sitting in ID.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_id_valid,
    input  logic [WORD_SIZE-1:0]         i_rs_data,
    input  logic [WORD_SIZE-1:0]         i_rt_data,
    input  logic [WORD_SIZE-1:0]         i_imm,
    input  logic [REG_ADDR-1:0]          i_rs_addr,
    input  logic [REG_ADDR-1:0]          i_rt_addr,
    input  logic [REG_ADDR-1:0]          i_dst_addr,
    input  logic [$clog2(WORD_SIZE)-1:0] i_shamt,
    input  logic [WORD_SIZE/4-1:0]       i_qbyte,
    input  logic [3:0]                   i_aluop,
    input  logic                         i_alusrc,
    input  logic                         i_regwrite,
    input  logic                         i_memread,
    input  logic                         i_memwrite,
    input  logic                         i_memtoreg,
    input  logic                         i_exmem_regwrite,
    input  logic [REG_ADDR-1:0]          i_exmem_dst,
    input  logic [WORD_SIZE-1:0]         i_exmem_result,
    input  logic                         i_memwb_regwrite,
    input  logic [REG_ADDR-1:0]          i_memwb_dst,
    input  logic [WORD_SIZE-1:0]         i_memwb_result,
    output logic                         o_ex_valid,
    output logic [WORD_SIZE-1:0]         o_alu_A,
    output logic [WORD_SIZE-1:0]         o_alu_B,
    output logic [WORD_SIZE-1:0]         o_store_data,
    output logic [$clog2(WORD_SIZE)-1:0] o_shamt,
    output logic [WORD_SIZE/4-1:0]       o_qbyte,
    output logic [3:0]                   o_aluop,
    output logic [REG_ADDR-1:0]          o_dst_addr,
    output logic                         o_regwrite,
    output logic                         o_memread,
    output logic                         o_memwrite,
    output logic                         o_memtoreg,
    output logic                         o_load_use
);

    localparam int SHAMT_W = $clog2(WORD_SIZE);
    localparam int QB_W    = WORD_SIZE / 4;

    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] rs_data;
        logic [WORD_SIZE-1:0] rt_data;
        logic [WORD_SIZE-1:0] imm;
        logic [REG_ADDR-1:0]  rs_addr;
        logic [REG_ADDR-1:0]  rt_addr;
        logic [REG_ADDR-1:0]  dst_addr;
        logic [SHAMT_W-1:0]   shamt;
        logic [QB_W-1:0]      qbyte;
        logic [3:0]           aluop;
        logic                 alusrc;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
        logic                 memtoreg;
    } id_ex_t;

    id_ex_t id_in;
    id_ex_t ex_q;

    logic [WORD_SIZE-1:0] fwd_a;
    logic [WORD_SIZE-1:0] fwd_b;

    // A non-valid ID slot enters EX as a bubble: add, no side effects.
    always_comb begin
        id_in          = '0;
        id_in.valid    = i_id_valid;
        id_in.rs_data  = i_rs_data;
        id_in.rt_data  = i_rt_data;
        id_in.imm      = i_imm;
        id_in.rs_addr  = i_rs_addr;
        id_in.rt_addr  = i_rt_addr;
        id_in.dst_addr = i_dst_addr;
        id_in.shamt    = i_shamt;
        id_in.qbyte    = i_qbyte;
        id_in.aluop    = i_id_valid ? i_aluop : ALU_ADD;
        id_in.alusrc   = i_alusrc;
        id_in.regwrite = i_regwrite & i_id_valid;
        id_in.memread  = i_memread  & i_id_valid;
        id_in.memwrite = i_memwrite & i_id_valid;
        id_in.memtoreg = i_memtoreg & i_id_valid;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            ex_q <= '0;
        else if (i_flush)
            ex_q <= '0;
        else if (!i_stall)
            ex_q <= id_in;
    end

    fwd_mux #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR  (REG_ADDR)
    ) u_fwd_rs (
        .src            (ex_q.rs_addr),
        .reg_data       (ex_q.rs_data),
        .exmem_regwrite (i_exmem_regwrite),
        .exmem_dst      (i_exmem_dst),
        .exmem_result   (i_exmem_result),
        .memwb_regwrite (i_memwb_regwrite),
        .memwb_dst      (i_memwb_dst),
        .memwb_result   (i_memwb_result),
        .data           (fwd_a)
    );

    fwd_mux #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR  (REG_ADDR)
    ) u_fwd_rt (
        .src            (ex_q.rt_addr),
        .reg_data       (ex_q.rt_data),
        .exmem_regwrite (i_exmem_regwrite),
        .exmem_dst      (i_exmem_dst),
        .exmem_result   (i_exmem_result),
        .memwb_regwrite (i_memwb_regwrite),
        .memwb_dst      (i_memwb_dst),
        .memwb_result   (i_memwb_result),
        .data           (fwd_b)
    );

    assign o_ex_valid   = ex_q.valid;
    assign o_alu_A      = fwd_a;
    assign o_store_data = fwd_b;
    assign o_alu_B      = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign o_shamt      = ex_q.shamt;
    assign o_qbyte      = ex_q.qbyte;
    assign o_aluop      = ex_q.aluop;
    assign o_dst_addr   = ex_q.dst_addr;
    assign o_regwrite   = ex_q.regwrite & ex_q.valid;
    assign o_memread    = ex_q.memread  & ex_q.valid;
    assign o_memwrite   = ex_q.memwrite & ex_q.valid;
    assign o_memtoreg   = ex_q.memtoreg & ex_q.valid;

    // A load in EX cannot feed the instruction in ID without a bubble.
    assign o_load_use = ex_q.valid & ex_q.memread
                      & (ex_q.dst_addr != '0) & i_id_valid
                      & ((ex_q.dst_addr == i_rs_addr)
                       | (ex_q.dst_addr == i_rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    logic        i_CLK;
    logic        i_RST;
    logic        i_stall;
    logic        i_flush;
    logic        i_id_valid;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic [31:0] i_imm;
    logic [4:0]  i_rs_addr;
    logic [4:0]  i_rt_addr;
    logic [4:0]  i_dst_addr;
    logic [4:0]  i_shamt;
    logic [7:0]  i_qbyte;
    logic [3:0]  i_aluop;
    logic        i_alusrc;
    logic        i_regwrite;
    logic        i_memread;
    logic        i_memwrite;
    logic        i_memtoreg;
    logic        i_exmem_regwrite;
    logic [4:0]  i_exmem_dst;
    logic [31:0] i_exmem_result;
    logic        i_memwb_regwrite;
    logic [4:0]  i_memwb_dst;
    logic [31:0] i_memwb_result;
    logic        o_ex_valid;
    logic [31:0] o_alu_A;
    logic [31:0] o_alu_B;
    logic [31:0] o_store_data;
    logic [4:0]  o_shamt;
    logic [7:0]  o_qbyte;
    logic [3:0]  o_aluop;
    logic [4:0]  o_dst_addr;
    logic        o_regwrite;
    logic        o_memread;
    logic        o_memwrite;
    logic        o_memtoreg;
    logic        o_load_use;

    id_ex_stage #(.WORD_SIZE(32), .REG_ADDR(5)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_id_valid(i_id_valid),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_dst_addr(i_dst_addr), .i_shamt(i_shamt),
        .i_qbyte(i_qbyte), .i_aluop(i_aluop), .i_alusrc(i_alusrc),
        .i_regwrite(i_regwrite), .i_memread(i_memread),
        .i_memwrite(i_memwrite), .i_memtoreg(i_memtoreg),
        .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_dst(i_exmem_dst),
        .i_exmem_result(i_exmem_result),
        .i_memwb_regwrite(i_memwb_regwrite), .i_memwb_dst(i_memwb_dst),
        .i_memwb_result(i_memwb_result),
        .o_ex_valid(o_ex_valid), .o_alu_A(o_alu_A), .o_alu_B(o_alu_B),
        .o_store_data(o_store_data), .o_shamt(o_shamt),
        .o_qbyte(o_qbyte), .o_aluop(o_aluop), .o_dst_addr(o_dst_addr),
        .o_regwrite(o_regwrite), .o_memread(o_memread),
        .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg),
        .o_load_use(o_load_use)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Model of the instruction currently held in EX.
    logic        m_valid;
    logic [31:0] m_rs_d, m_rt_d, m_imm;
    logic [4:0]  m_rs, m_rt, m_dst, m_shamt;
    logic [7:0]  m_qb;
    logic [3:0]  m_op;
    logic        m_src, m_rw, m_mr, m_mw, m_mt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_rs_d = 0; m_rt_d = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_dst = 0; m_shamt = 0; m_qb = 0;
        m_op = 0; m_src = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mt = 0;
    endtask

    // Flush beats stall beats load; a non-valid instruction is a bubble.
    task automatic model_edge();
        if (i_flush) begin
            model_clear();
        end else if (!i_stall) begin
            m_valid = i_id_valid;
            m_rs_d = i_rs_data; m_rt_d = i_rt_data; m_imm = i_imm;
            m_rs = i_rs_addr; m_rt = i_rt_addr; m_dst = i_dst_addr;
            m_shamt = i_shamt; m_qb = i_qbyte; m_src = i_alusrc;
            m_op = i_id_valid ? i_aluop : 4'd0;
            m_rw = i_id_valid && i_regwrite;
            m_mr = i_id_valid && i_memread;
            m_mw = i_id_valid && i_memwrite;
            m_mt = i_id_valid && i_memtoreg;
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src,
                                        input logic [31:0] regv);
        if (src != 0 && i_exmem_regwrite && i_exmem_dst == src)
            return i_exmem_result;
        if (src != 0 && i_memwb_regwrite && i_memwb_dst == src)
            return i_memwb_result;
        return regv;
    endfunction

    task automatic check_all(input string ph);
        logic [31:0] ea, eb, es;
        logic        lu;
        ea = fwd(m_rs, m_rs_d);
        es = fwd(m_rt, m_rt_d);
        eb = m_src ? m_imm : es;
        lu = m_valid && m_mr && m_dst != 0 && i_id_valid
             && (m_dst == i_rs_addr || m_dst == i_rt_addr);
        chk({ph, "/valid"}, 32'(o_ex_valid), 32'(m_valid));
        chk({ph, "/alu_A"}, o_alu_A, ea);
        chk({ph, "/alu_B"}, o_alu_B, eb);
        chk({ph, "/store"}, o_store_data, es);
        chk({ph, "/shamt"}, 32'(o_shamt), 32'(m_shamt));
        chk({ph, "/qbyte"}, 32'(o_qbyte), 32'(m_qb));
        chk({ph, "/aluop"}, 32'(o_aluop), 32'(m_op));
        chk({ph, "/dst"}, 32'(o_dst_addr), 32'(m_dst));
        chk({ph, "/ctrl"},
            32'({o_regwrite, o_memread, o_memwrite, o_memtoreg}),
            32'({m_rw, m_mr, m_mw, m_mt}));
        chk({ph, "/load_use"}, 32'(o_load_use), 32'(lu));
    endtask

    task automatic cycle(input string ph);
        @(posedge i_CLK);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic idle();
        i_stall = 0; i_flush = 0; i_id_valid = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0;
        i_rs_addr = 0; i_rt_addr = 0; i_dst_addr = 0;
        i_shamt = 0; i_qbyte = 0; i_aluop = 0; i_alusrc = 0;
        i_regwrite = 0; i_memread = 0; i_memwrite = 0; i_memtoreg = 0;
        i_exmem_regwrite = 0; i_exmem_dst = 0; i_exmem_result = 0;
        i_memwb_regwrite = 0; i_memwb_dst = 0; i_memwb_result = 0;
    endtask

    task automatic rand_id();
        i_id_valid = 1'($urandom_range(0, 3) != 0);
        i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
        i_rs_addr = 5'($urandom_range(0, 7));
        i_rt_addr = 5'($urandom_range(0, 7));
        i_dst_addr = 5'($urandom_range(0, 7));
        i_shamt = 5'($urandom); i_qbyte = 8'($urandom);
        i_aluop = 4'($urandom_range(0, 11));
        i_alusrc = 1'($urandom); i_regwrite = 1'($urandom);
        i_memread = 1'($urandom); i_memwrite = 1'($urandom);
        i_memtoreg = 1'($urandom);
    endtask

    task automatic rand_all();
        rand_id();
        i_flush = 1'($urandom_range(0, 9) == 0);
        i_stall = 1'($urandom_range(0, 4) == 0);
        i_exmem_regwrite = 1'($urandom);
        i_exmem_dst = 5'($urandom_range(0, 7));
        i_exmem_result = $urandom;
        i_memwb_regwrite = 1'($urandom);
        i_memwb_dst = 5'($urandom_range(0, 7));
        i_memwb_result = $urandom;
    endtask

    initial begin
        logic [31:0] r;
        idle();
        i_RST = 1;
        model_clear();
        repeat (2) @(negedge i_CLK);
        i_RST = 0;
        #1;
        check_all("reset");
        chk("reset_valid", 32'(o_ex_valid), 32'd0);

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_aluop = 4'd1;
        i_rs_addr = 5; i_rs_data = 32'h11;
        i_rt_addr = 6; i_rt_data = 32'h22;
        cycle("pass");
        chk("pass_A", o_alu_A, 32'h11);
        chk("pass_B", o_alu_B, 32'h22);

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_rs_addr = 3; i_rs_data = 32'h1234;
        cycle("dbl_load");
        @(negedge i_CLK);
        i_exmem_regwrite = 1; i_exmem_dst = 3; i_exmem_result = 32'hAAAA;
        i_memwb_regwrite = 1; i_memwb_dst = 3; i_memwb_result = 32'hBBBB;
        #1;
        check_all("dbl");
        chk("dbl_A", o_alu_A, 32'hAAAA);
        i_exmem_regwrite = 0;
        #1;
        chk("memwb_A", o_alu_A, 32'hBBBB);

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_rs_addr = 0; i_rs_data = 0;
        cycle("r0_load");
        @(negedge i_CLK);
        i_exmem_regwrite = 1; i_exmem_dst = 0; i_exmem_result = 32'hFFFF;
        #1;
        chk("r0_A", o_alu_A, 32'h0);

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_memread = 1; i_regwrite = 1; i_memtoreg = 1;
        i_dst_addr = 7; i_rs_addr = 1; i_rt_addr = 2;
        cycle("lw");
        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_rs_addr = 4; i_rt_addr = 7;
        #1;
        check_all("lu_id");
        chk("load_use", 32'(o_load_use), 32'd1);
        i_stall = 1; i_flush = 1;
        cycle("lu_flush");
        chk("flush_valid", 32'(o_ex_valid), 32'd0);
        chk("flush_rw", 32'(o_regwrite), 32'd0);

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_rs_addr = 9; i_rs_data = 32'h99;
        i_aluop = 4'd3; i_regwrite = 1;
        cycle("st_load");
        for (int k = 0; k < 3; k++) begin
            @(negedge i_CLK);
            rand_id();
            i_stall = 1; i_flush = 0;
            r = $urandom;
            i_exmem_regwrite = 1; i_exmem_dst = 9; i_exmem_result = r;
            #1;
            chk("stall_A", o_alu_A, r);
            cycle("stall");
            chk("stall_op", 32'(o_aluop), 32'd3);
        end

        @(negedge i_CLK);
        idle();
        i_id_valid = 1; i_rs_addr = 2; i_rs_data = 32'h55;
        i_regwrite = 1; i_aluop = 4'd7;
        cycle("pre_rst");
        @(negedge i_CLK);
        #2;
        i_RST = 1;
        #1;
        model_clear();
        check_all("rst_mid");
        chk("rst_valid", 32'(o_ex_valid), 32'd0);
        @(posedge i_CLK);
        #1;
        check_all("rst_hold");
        @(negedge i_CLK);
        i_RST = 0;
        cycle("post_rst");
        chk("post_rst_valid", 32'(o_ex_valid), 32'd1);

        repeat (400) begin
            @(negedge i_CLK);
            rand_all();
            #1;
            check_all("rnd_comb");
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
